// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state encodings, requester IDs and
// the default BUSY timeout.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StResp = 2'd2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_EXT = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker; the last-grant history is held by the caller.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_valid_o = |req_i;
        case (req_i)
            2'b01:   grant_id_o = REQ_CPU;
            2'b10:   grant_id_o = REQ_EXT;
            // On a tie the requester that did not win last time goes first.
            2'b11:   grant_id_o = ~last_i;
            default: grant_id_o = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / external) arbiter for the single unified memory port.
// Optional BUSY timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              cpu_err_o,

    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_ready_o,
    output logic              ext_err_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("mem_arbiter: TIMEOUT must be at least 2");
    end

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              ext_ready_q, ext_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic              ext_err_q, ext_err_d;

    logic              grant_valid;
    logic              grant_id;
    logic              timeout_hit;

    mem_arb_rr u_rr (
        .req_i         ({ext_req_i, cpu_req_i}),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside BUSY so each BUSY entry starts a fresh count.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StBusy) begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == StBusy) && (tmo_cnt_q == CntW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cpu_ready_d = 1'b0;
        ext_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        ext_err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d  = StBusy;
                    owner_d  = grant_id;
                    last_d   = grant_id;
                    mem_en_d = 1'b1;
                    if (grant_id == REQ_EXT) begin
                        mem_we_d    = ext_we_i;
                        mem_addr_d  = ext_addr_i;
                        mem_wdata_d = ext_wdata_i;
                    end else begin
                        mem_we_d    = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                end
            end

            StBusy: begin
                // A real ack beats a terminal count landing in the same cycle.
                if (mem_ack_i || timeout_hit) begin
                    state_d  = StResp;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    rdata_d  = mem_ack_i ? mem_rdata_i : '0;
                    if (owner_q == REQ_EXT) begin
                        ext_ready_d = 1'b1;
                        ext_err_d   = ~mem_ack_i;
                    end else begin
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = ~mem_ack_i;
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= REQ_CPU;
            last_q      <= REQ_EXT;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            cpu_ready_q <= 1'b0;
            ext_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            ext_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            cpu_ready_q <= cpu_ready_d;
            ext_ready_q <= ext_ready_d;
            cpu_err_q   <= cpu_err_d;
            ext_err_q   <= ext_err_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Both ports see the same response register; it is only meaningful with ready.
    assign cpu_rdata_o = rdata_q;
    assign ext_rdata_o = rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign ext_ready_o = ext_ready_q;
    assign cpu_err_o   = cpu_err_q;
    assign ext_err_o   = ext_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard of expected ready pulses,
// and hand-written reset-abort, contention, stray-ack and (MEM_ARB_TIMEOUT_EN) timeout cases.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, mem_wdata;
    logic [DW-1:0] cpu_rdata, ext_rdata, mem_rdata;
    logic          cpu_ready, ext_ready, cpu_err, ext_err;
    logic          mem_en, mem_we, mem_ack;
    logic          model_ack, stray_ack;

    assign mem_ack = model_ack | stray_ack;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .cpu_err_o   (cpu_err),
        .ext_req_i   (ext_req),
        .ext_we_i    (ext_we),
        .ext_addr_i  (ext_addr),
        .ext_wdata_i (ext_wdata),
        .ext_rdata_o (ext_rdata),
        .ext_ready_o (ext_ready),
        .ext_err_o   (ext_err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: acks after mem_wait wait cycles of BUSY, or never when no_ack is set.
    int          mem_wait = 0;
    int          wcnt     = 0;
    bit          no_ack   = 1'b0;
    logic [31:0] mem_resp = '0;

    always @(posedge clk) begin
        #1;
        model_ack = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        if (!mem_en) begin
            wcnt = 0;
        end else if (!no_ack) begin
            if (wcnt == mem_wait) begin
                model_ack = 1'b1;
                mem_rdata = mem_resp;
            end
            wcnt++;
        end
    end

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_ready && ext_ready) check("both_ready", 1, 0);
            if (cpu_ready || ext_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: cpu_ready=%b ext_ready=%b, none expected",
                             cpu_ready, ext_ready);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ready_port", {63'd0, ext_ready}, {63'd0, mon_e.port});
                    check("ready_cycle", 64'(cyc), 64'(mon_e.cycle));
                    check("ready_err", {63'd0, ext_ready ? ext_err : cpu_err},
                          {63'd0, mon_e.err});
                    if (mon_e.chk_rdata) begin
                        check("ready_rdata", {32'd0, ext_ready ? ext_rdata : cpu_rdata},
                              {32'd0, mon_e.rdata});
                    end
                end
            end
        end
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        ext_req;
        logic        ext_we;
        logic [31:0] ext_addr;
        logic [31:0] ext_wdata;
        int          waits;
        logic [31:0] resp;
        logic        exp_port;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        cpu_req = 1'b0;
        ext_req = 1'b0;
        cpu_we  = 1'b0;
        ext_we  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_reqs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic        we;
        logic [31:0] a, wd;
        exp_t        e;
        int          busy;
        bit          got;
        cpu_req   = v.cpu_req;
        cpu_we    = v.cpu_we;
        cpu_addr  = v.cpu_addr;
        cpu_wdata = v.cpu_wdata;
        ext_req   = v.ext_req;
        ext_we    = v.ext_we;
        ext_addr  = v.ext_addr;
        ext_wdata = v.ext_wdata;
        mem_wait  = v.waits;
        mem_resp  = v.resp;
        we = v.exp_port ? v.ext_we : v.cpu_we;
        a  = v.exp_port ? v.ext_addr : v.cpu_addr;
        wd = v.exp_port ? v.ext_wdata : v.cpu_wdata;
        e.port      = v.exp_port;
        e.rdata     = v.resp;
        e.chk_rdata = ~we;
        e.err       = 1'b0;
        e.cycle     = cyc + 2 + v.waits;
        sbq.push_back(e);
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (mem_en) begin
                busy++;
                check("mem_we", {63'd0, mem_we}, {63'd0, we});
                check("mem_addr", {32'd0, mem_addr}, {32'd0, a});
                check("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
            end
            if (cpu_ready || ext_ready) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL vec_ready_timeout: no ready within 40 cycles, expected one");
        end
        check("busy_cycles", 64'(busy), 64'(v.waits + 1));
        drop_reqs();
        step();
    endtask

    initial begin : main
        int   c0;
        int   seen;
        exp_t e;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    0, 32'hDEAD_BEEF, REQ_CPU};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5A,
                    2, 32'h0BAD_CAFE, REQ_EXT};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h1, 1'b1, 1'b0, 32'h200, 32'h2,
                    1, 32'h1111_2222, REQ_CPU};
        vecs[3] = '{1'b1, 1'b1, 32'h104, 32'h77, 1'b1, 1'b0, 32'h204, 32'h3,
                    0, 32'h3333_4444, REQ_EXT};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h4,
                    3, 32'h5555_6666, REQ_EXT};
        vecs[5] = '{1'b1, 1'b0, 32'h10C, 32'h5, 1'b1, 1'b1, 32'h20C, 32'hA5,
                    0, 32'h7777_8888, REQ_CPU};
        vecs[6] = '{1'b1, 1'b1, 32'h110, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0,
                    1, 32'h1234_5678, REQ_CPU};
        vecs[7] = '{1'b1, 1'b0, 32'h114, 32'h6, 1'b1, 1'b0, 32'h214, 32'h7,
                    2, 32'h9999_AAAA, REQ_EXT};

        stray_ack = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ext_addr  = '0;
        ext_wdata = '0;
        do_reset();
        #1;
        check("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_ready", {62'd0, cpu_ready, ext_ready}, 64'd0);
        check("rst_err", {62'd0, cpu_err, ext_err}, 64'd0);
        check("rst_rdata", {cpu_rdata, ext_rdata}, 64'd0);
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters held high from reset: strict alternation, 3 cycles apart.
        do_reset();
        step();
        cpu_addr  = 32'h300;
        ext_addr  = 32'h400;
        mem_wait  = 0;
        mem_resp  = 32'h00C0_FFEE;
        cpu_req   = 1'b1;
        ext_req   = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            e.port      = (k % 2 == 0) ? REQ_CPU : REQ_EXT;
            e.rdata     = 32'h00C0_FFEE;
            e.chk_rdata = 1'b1;
            e.err       = 1'b0;
            e.cycle     = c0 + 2 + 3 * k;
            sbq.push_back(e);
        end
        seen = 0;
        for (int i = 0; i < 60 && seen < 4; i++) begin
            step();
            if (cpu_ready || ext_ready) seen++;
        end
        check("contend_count", 64'(seen), 64'd4);
        drop_reqs();
        step();

        // Abort a CPU access mid-BUSY; its grant must not survive into last.
        cpu_addr = 32'h40;
        mem_wait = 5;
        cpu_req  = 1'b1;
        step();
        check("abort_busy", {63'd0, mem_en}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_async_en", {63'd0, mem_en}, 64'd0);
        check("abort_async_rdy", {62'd0, cpu_ready, ext_ready}, 64'd0);
        step();
        reset = 1'b0;
        drop_reqs();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cpu_ready || ext_ready || mem_en) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        run_vec(vecs[2]);

        // Stray ack in IDLE must be ignored.
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_ready || ext_ready || mem_en) seen++;
        end
        check("stray_quiet", 64'(seen), 64'd0);
        run_vec(vecs[6]);

`ifdef MEM_ARB_TIMEOUT_EN
        no_ack   = 1'b1;
        cpu_addr = 32'h50;
        cpu_req  = 1'b1;
        e.port      = REQ_CPU;
        e.rdata     = 32'h0;
        e.chk_rdata = 1'b1;
        e.err       = 1'b1;
        e.cycle     = cyc + 5;
        sbq.push_back(e);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (cpu_ready || ext_ready) seen++;
        end
        check("timeout_ready", 64'(seen), 64'd1);
        drop_reqs();
        no_ack = 1'b0;
        step();
`endif

        step();
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified memory of the multicycle processor. It shares the one memory port between the CPU port (fetch and load/store, driven by the main control FSM's AdrSrc/MemW sequencing) and an external port used by the program loader or debug DMA. Each access is registered, issued, and completed as one transaction. The granted requester receives a one-cycle `ready` pulse with read data; the other requester is stalled.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: cycles in BUSY without `mem_ack` before the access is aborted. Used only with `MEM_ARB_TIMEOUT_EN`. Must be ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU access request, level.
- `cpu_we`  in  1  1 = write.
- `cpu_addr`  in  ADDR_W  address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ready` is high.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  timeout flag, valid with `cpu_ready`.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_rdata`, `ext_ready`, `ext_err`: identical to the CPU set, for the external port.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  registered address.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion from memory.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any `*_req` is high, pick a winner and latch `we`/`addr`/`wdata` into the memory-side registers.
  - Record the winner in `owner` and in `last`, then go to BUSY.
  - If no request is high, stay in IDLE.
- Arbitration is 2-way round-robin:
  - Only one requester high: it wins.
  - Both high: the one ≠ `last` wins.
  - `last` resets to EXT, so the CPU wins the first tie.
- BUSY:
  - `mem_en` = 1; `mem_we` holds the latched value.
  - On `mem_ack`, capture `mem_rdata` into the response register and go to RESP.
- RESP:
  - `owner`'s `ready` = 1 for exactly one cycle, with `rdata` = captured data and `err` = captured flag.
  - The non-owner's `ready` stays 0.
  - Next state is IDLE.
- Requester rules:
  - Hold `req` and all fields stable until its `ready` pulse.
  - Drop `req` in the cycle after `ready` unless another access is wanted. A `req` still high in IDLE is a new access.
- Write transactions also complete with `ready`. `rdata` is then don't-care; it holds the last `mem_rdata` capture.
- Requests arriving in BUSY or RESP wait; they are evaluated only in IDLE.
- `mem_ack` outside BUSY is ignored.
- Reset values:
  - State IDLE; `last` = EXT.
  - `mem_en`, `mem_we`, all `ready`, all `err` = 0.
  - `mem_addr`, `mem_wdata`, all `rdata` = 0.
- Reset mid-transaction: `mem_en` falls immediately (asynchronous). The transaction is dropped with no `ready`, and the memory must tolerate an aborted access.

## Timing
- Zero-wait memory (`mem_ack` in the first BUSY cycle):
  - `req` sampled in IDLE at cycle 0.
  - BUSY in cycle 1.
  - `ready` in cycle 2.
  - IDLE in cycle 3.
- Latency is 2 + W cycles, where W is the number of wait cycles before `mem_ack`.
- Back-to-back throughput: one transaction per 3 + W cycles.
- Both requesters held high continuously: grants strictly alternate (CPU, EXT, CPU, ...).
- All outputs are registered. There is no combinational path from `*_req` or `mem_ack` to any output.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in BUSY and clears on entry to BUSY.
  - If the counter reaches `TIMEOUT`-1 with no `mem_ack`, go to RESP with `err` = 1 and `rdata` = 0; `mem_en` drops the same edge.
  - `mem_ack` arriving in the same cycle as the terminal count wins: normal completion, `err` = 0.
- Undefined: no counter is instantiated, `*_err` are tied to 0, and BUSY waits indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/RESP);
  - requester IDs `REQ_CPU` = 0 and `REQ_EXT` = 1;
  - the default `TIMEOUT` constant.
- Sub-module `mem_arb_rr` is the 2-way round-robin picker. Inputs: `req[1:0]`, `last`. Outputs: `grant_valid`, `grant_id`. It is combinational; `last` is held in `mem_arbiter`.

## Test plan
- Single CPU read:
  - Stimulus: `cpu_req`, `addr` = 0x10, memory acks in the first BUSY cycle with 0xDEADBEEF.
  - Required: `cpu_ready` in cycle 2 with `cpu_rdata` = 0xDEADBEEF; `ext_ready` stays 0.
- EXT write, two wait states:
  - Stimulus: `ext_we` = 1, `addr` = 0x20, `wdata` = 0x5A.
  - Required: `mem_we` = 1, `mem_addr` = 0x20, `mem_wdata` = 0x5A held 3 BUSY cycles; `ext_ready` in cycle 4.
- Contention:
  - Stimulus: both `req` held high for 4 transactions from reset.
  - Required: grant order CPU, EXT, CPU, EXT; each `ready` arrives 3 cycles apart with zero-wait memory.
- Reset during BUSY:
  - Stimulus: assert `reset`.
  - Required: `mem_en` goes to 0 with no clock edge; no `ready`; after release the first tie goes to CPU.
- Timeout, with `MEM_ARB_TIMEOUT_EN` and `TIMEOUT` = 4:
  - Stimulus: never ack.
  - Required: `cpu_ready` = 1, `cpu_err` = 1, `cpu_rdata` = 0 in cycle 5.
- Stray ack:
  - Stimulus: `mem_ack` pulsed in IDLE.
  - Required: no `ready`, state stays IDLE.
